// File: rtl/act_pwl_if.sv
// Sample/result handshake bundle for act_pwl: input sample side and result side.
interface act_pwl_if #(
  parameter int DATA_W = 16,
  parameter int TAG_W  = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_x;
  logic              in_mode;
  logic [TAG_W-1:0]  in_tag;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_y;
  logic [TAG_W-1:0]  out_tag;

  modport master (
    output in_valid, in_x, in_mode, in_tag, out_ready,
    input  in_ready, out_valid, out_y, out_tag
  );

  modport slave (
    input  in_valid, in_x, in_mode, in_tag, out_ready,
    output in_ready, out_valid, out_y, out_tag
  );
endinterface

// File: rtl/act_pwl.sv
// Piecewise-linear tanh/sigmoid on signed fixed-point samples, tag carried alongside.
// 3-cycle latency, 1 sample/cycle; a stalled output freezes the whole pipe and drops in_ready.
module act_pwl #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int TAG_W  = 4
) (
  input logic      clk,
  input logic      rst,
  act_pwl_if.slave io
);

  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] MAX_POS  = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] C_0P25   = DATA_W'(1) << (FRAC_W - 2);
  localparam logic [DATA_W-1:0] C_0P5    = DATA_W'(1) << (FRAC_W - 1);
  localparam logic [DATA_W-1:0] C_0P6875 = DATA_W'(11) << (FRAC_W - 4);
  localparam logic [DATA_W-1:0] C_0P8125 = DATA_W'(13) << (FRAC_W - 4);
  localparam logic [DATA_W-1:0] C_1P0    = DATA_W'(1) << FRAC_W;
  localparam logic [DATA_W-1:0] C_1P5    = DATA_W'(3) << (FRAC_W - 1);
  localparam logic [DATA_W-1:0] C_2P0    = DATA_W'(1) << (FRAC_W + 1);
  localparam logic [DATA_W-1:0] C_3P0    = DATA_W'(3) << FRAC_W;

  logic adv;

  // S1: fold and segment select
  logic                     s1_vld_d, s1_vld_q;
  logic                     s1_neg_d, s1_neg_q;
  logic                     s1_mode_d, s1_mode_q;
  logic [DATA_W-1:0]        s1_mag_d, s1_mag_q;
  logic [2:0]               s1_seg_d, s1_seg_q;
  logic [TAG_W-1:0]         s1_tag_d, s1_tag_q;
  logic signed [DATA_W-1:0] x_half;
  logic [DATA_W-1:0]        x_pre;

  // S2: shift-add
  logic                     s2_vld_d, s2_vld_q;
  logic                     s2_neg_d, s2_neg_q;
  logic                     s2_mode_d, s2_mode_q;
  logic [DATA_W-1:0]        s2_m_d, s2_m_q;
  logic [TAG_W-1:0]         s2_tag_d, s2_tag_q;

  // S3: sign restore and sigmoid post-scale
  logic                     s3_vld_d, s3_vld_q;
  logic [DATA_W-1:0]        s3_y_d, s3_y_q;
  logic [TAG_W-1:0]         s3_tag_d, s3_tag_q;
  logic [DATA_W-1:0]        t_val;
  logic signed [DATA_W-1:0] t_half;
  logic [DATA_W-1:0]        sig_y;

  assign adv          = ~s3_vld_q | io.out_ready;
  assign io.in_ready  = adv;
  assign io.out_valid = s3_vld_q;
  assign io.out_y     = s3_y_q;
  assign io.out_tag   = s3_tag_q;

  always_comb begin
    x_half    = $signed(io.in_x) >>> 1;
    x_pre     = io.in_mode ? x_half : io.in_x;
    s1_vld_d  = io.in_valid;
    s1_mode_d = io.in_mode;
    s1_tag_d  = io.in_tag;
    s1_neg_d  = x_pre[DATA_W-1];
    // The most-negative sample has no positive twin; clamp its magnitude.
    if (x_pre == MOST_NEG) begin
      s1_mag_d = MAX_POS;
    end else if (s1_neg_d) begin
      s1_mag_d = -x_pre;
    end else begin
      s1_mag_d = x_pre;
    end
    if (s1_mag_d < C_0P5) begin
      s1_seg_d = 3'd0;
    end else if (s1_mag_d < C_1P0) begin
      s1_seg_d = 3'd1;
    end else if (s1_mag_d < C_1P5) begin
      s1_seg_d = 3'd2;
    end else if (s1_mag_d < C_2P0) begin
      s1_seg_d = 3'd3;
    end else if (s1_mag_d < C_3P0) begin
      s1_seg_d = 3'd4;
    end else begin
      s1_seg_d = 3'd5;
    end
  end

  always_comb begin
    s2_vld_d  = s1_vld_q;
    s2_neg_d  = s1_neg_q;
    s2_mode_d = s1_mode_q;
    s2_tag_d  = s1_tag_q;
    case (s1_seg_q)
      3'd0:    s2_m_d = s1_mag_q;
      3'd1:    s2_m_d = (s1_mag_q >> 1) + C_0P25;
      3'd2:    s2_m_d = (s1_mag_q >> 2) + C_0P5;
      3'd3:    s2_m_d = (s1_mag_q >> 3) + C_0P6875;
      3'd4:    s2_m_d = (s1_mag_q >> 4) + C_0P8125;
      default: s2_m_d = C_1P0;
    endcase
  end

  always_comb begin
    s3_vld_d = s2_vld_q;
    s3_tag_d = s2_tag_q;
    t_val    = s2_neg_q ? -s2_m_q : s2_m_q;
    t_half   = $signed(t_val) >>> 1;
    sig_y    = t_half + C_0P5;
    s3_y_d   = s2_mode_q ? sig_y : t_val;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_vld_q  <= 1'b0;
      s1_neg_q  <= 1'b0;
      s1_mode_q <= 1'b0;
      s1_mag_q  <= '0;
      s1_seg_q  <= '0;
      s1_tag_q  <= '0;
      s2_vld_q  <= 1'b0;
      s2_neg_q  <= 1'b0;
      s2_mode_q <= 1'b0;
      s2_m_q    <= '0;
      s2_tag_q  <= '0;
      s3_vld_q  <= 1'b0;
      s3_y_q    <= '0;
      s3_tag_q  <= '0;
    end else if (adv) begin
      s1_vld_q  <= s1_vld_d;
      s1_neg_q  <= s1_neg_d;
      s1_mode_q <= s1_mode_d;
      s1_mag_q  <= s1_mag_d;
      s1_seg_q  <= s1_seg_d;
      s1_tag_q  <= s1_tag_d;
      s2_vld_q  <= s2_vld_d;
      s2_neg_q  <= s2_neg_d;
      s2_mode_q <= s2_mode_d;
      s2_m_q    <= s2_m_d;
      s2_tag_q  <= s2_tag_d;
      s3_vld_q  <= s3_vld_d;
      s3_y_q    <= s3_y_d;
      s3_tag_q  <= s3_tag_d;
    end
  end

endmodule

// File: tb/tb_act_pwl.sv
// Self-checking bench for act_pwl: directed vectors, backpressure, mixed mode, reset, random.
module tb_act_pwl;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  act_pwl_if #(.DATA_W(16), .TAG_W(4)) bus ();

  act_pwl #(.DATA_W(16), .FRAC_W(8), .TAG_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  typedef struct {
    logic [3:0]  tag;
    logic [15:0] y;
  } exp_t;

  typedef struct {
    logic [15:0] x;
    logic        mode;
    logic [15:0] y;
  } vec_t;

  int          checks;
  int          errors;
  int          out_count;
  exp_t        exp_q[$];
  logic        last_pop_vld;
  logic [15:0] last_pop_y;
  vec_t        vt[12];
  logic [15:0] sp[0:9];

  // Reference: real-valued segment selection, floor division for the shifts.
  function automatic logic [15:0] ref_y(logic [15:0] x, logic mode);
    int  xv, a, m, t, y;
    real ar;
    xv = int'($signed(x));
    if (mode) xv = (xv >= 0) ? xv / 2 : -((1 - xv) / 2);
    a = (xv < 0) ? -xv : xv;
    if (a > 32767) a = 32767;
    ar = real'(a) / 256.0;
    if (ar < 0.5)      m = a;
    else if (ar < 1.0) m = a / 2 + 64;
    else if (ar < 1.5) m = a / 4 + 128;
    else if (ar < 2.0) m = a / 8 + 176;
    else if (ar < 3.0) m = a / 16 + 208;
    else               m = 256;
    t = (xv < 0) ? -m : m;
    if (mode) y = ((t >= 0) ? t / 2 : -((1 - t) / 2)) + 128;
    else      y = t;
    return 16'(y);
  endfunction

  task automatic chk(string nm, logic [15:0] act, logic [15:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, expv);
    end
  endtask

  // One clock: scoreboard the pre-edge handshake, then advance past the edge.
  task automatic step();
    logic live, xi, xo;
    exp_t e;
    #1;
    live = rst;
    xi   = bus.in_valid & bus.in_ready;
    xo   = bus.out_valid & bus.out_ready;
    last_pop_vld = 1'b0;
    if (live && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got y=%h tag=%h, expected no result", bus.out_y, bus.out_tag);
      end else begin
        chk("sb_y", bus.out_y, exp_q[0].y);
        chk("sb_tag", 16'(bus.out_tag), 16'(exp_q[0].tag));
        if (xo) begin
          last_pop_vld = 1'b1;
          last_pop_y   = bus.out_y;
          void'(exp_q.pop_front());
          out_count++;
        end
      end
    end
    if (live && xi) begin
      e.tag = bus.in_tag;
      e.y   = ref_y(bus.in_x, bus.in_mode);
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(string nm, logic [15:0] x, logic m, logic [3:0] tg, logic [15:0] y);
    bus.in_x      = x;
    bus.in_mode   = m;
    bus.in_tag    = tg;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    chk({nm, "_ready"}, 16'(bus.in_ready), 16'd1);
    step();
    bus.in_valid = 1'b0;
    chk({nm, "_c1_vld"}, 16'(bus.out_valid), 16'd0);
    step();
    chk({nm, "_c2_vld"}, 16'(bus.out_valid), 16'd0);
    step();
    chk({nm, "_c3_vld"}, 16'(bus.out_valid), 16'd1);
    chk({nm, "_y"}, bus.out_y, y);
    chk({nm, "_tag"}, 16'(bus.out_tag), 16'(tg));
    step();
    chk({nm, "_c4_vld"}, 16'(bus.out_valid), 16'd0);
  endtask

  initial begin
    int          sent;
    int          base;
    logic [15:0] const_q[$];
    logic [3:0]  rtag;

    checks = 0;
    errors = 0;
    out_count = 0;
    last_pop_vld = 1'b0;
    last_pop_y = '0;

    vt[0]  = '{16'h0040, 1'b0, 16'h0040};
    vt[1]  = '{16'h00C0, 1'b0, 16'h00A0};
    vt[2]  = '{16'hFF40, 1'b0, 16'hFF60};
    vt[3]  = '{16'h0400, 1'b0, 16'h0100};
    vt[4]  = '{16'h8000, 1'b0, 16'hFF00};
    vt[5]  = '{16'h0080, 1'b0, 16'h0080};
    vt[6]  = '{16'h0300, 1'b0, 16'h0100};
    vt[7]  = '{16'h0000, 1'b1, 16'h0080};
    vt[8]  = '{16'h0200, 1'b1, 16'h00E0};
    vt[9]  = '{16'hFE00, 1'b1, 16'h0020};
    vt[10] = '{16'h7FFF, 1'b1, 16'h0100};
    vt[11] = '{16'h0200, 1'b0, 16'h00F0};

    sp = '{16'h8000, 16'h7FFF, 16'h0080, 16'h0100, 16'h0180,
           16'h0200, 16'h0300, 16'hFF80, 16'hFD00, 16'h007F};

    // Reset state
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_x = '0;
    bus.in_mode = 1'b0;
    bus.in_tag = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 16'(bus.out_valid), 16'd0);
    chk("rst_out_y", bus.out_y, 16'h0000);
    chk("rst_out_tag", 16'(bus.out_tag), 16'd0);
    rst = 1'b1;
    step();
    chk("rst_in_ready", 16'(bus.in_ready), 16'd1);

    // Directed vectors
    for (int i = 0; i < 12; i++) begin
      run_vec($sformatf("vec%0d", i), vt[i].x, vt[i].mode, 4'(i), vt[i].y);
    end

    // Backpressure: 8 tagged samples, out_ready low for cycles 4..8
    base = out_count;
    sent = 0;
    for (int c = 0; c < 40 && (sent < 8 || exp_q.size() > 0); c++) begin
      bus.out_ready = !(c >= 4 && c <= 8);
      bus.in_valid  = (sent < 8);
      bus.in_x      = 16'($urandom);
      bus.in_mode   = 1'($urandom);
      bus.in_tag    = 4'(sent);
      #1;
      chk("bp_in_ready", 16'(bus.in_ready), 16'(!(c >= 4 && c <= 8)));
      if (bus.in_valid && bus.in_ready) sent++;
      step();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    chk("bp_sent", 16'(sent), 16'd8);
    chk("bp_out_count", 16'(out_count - base), 16'd8);

    // Mixed mode: x=2.0 alternating tanh/sigmoid
    base = out_count;
    for (int i = 0; i < 8; i++) begin
      const_q.push_back(i[0] ? 16'h00E0 : 16'h00F0);
    end
    for (int i = 0; i < 18 && (out_count - base) < 8; i++) begin
      bus.in_valid = (i < 8);
      bus.in_x     = 16'h0200;
      bus.in_mode  = i[0];
      bus.in_tag   = 4'(i);
      step();
      if (last_pop_vld && const_q.size() > 0) chk("mixed_y", last_pop_y, const_q.pop_front());
    end
    bus.in_valid = 1'b0;
    chk("mixed_count", 16'(out_count - base), 16'd8);

    // Reset with 3 samples in flight
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1;
      bus.in_x     = 16'h0100 + 16'(i);
      bus.in_mode  = 1'b0;
      bus.in_tag   = 4'(9 + i);
      step();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    rst = 1'b0;
    step();
    exp_q.delete();
    chk("mid_rst_out_valid", 16'(bus.out_valid), 16'd0);
    chk("mid_rst_out_y", bus.out_y, 16'h0000);
    rst = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    chk("mid_rst_in_ready", 16'(bus.in_ready), 16'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("mid_rst_quiet", 16'(bus.out_valid), 16'd0);
    end
    run_vec("post_rst", 16'h00C0, 1'b0, 4'd5, 16'h00A0);

    // Random traffic against the reference model
    rtag = '0;
    for (int i = 0; i < 400; i++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 9) < 7);
      bus.in_x      = ($urandom_range(0, 5) == 0) ? sp[$urandom_range(0, 9)] : 16'($urandom);
      bus.in_mode   = 1'($urandom);
      bus.in_tag    = rtag;
      rtag          = rtag + 4'd1;
      step();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 30 && exp_q.size() > 0; k++) step();
    chk("drain_empty", 16'(exp_q.size()), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/act_pwl.md
ACT_PWL -- requirements
Module: act_pwl

Interface
REQ-001 Parameters: DATA_W, default 16, meaning signed two's-complement sample width; FRAC_W, default 8, meaning fractional bits with legal range 4..DATA_W-3; TAG_W, default 4, meaning sideband tag width.
REQ-002 Ports: clk  in  1  clock, all logic on rising edge.
REQ-003 Ports: rst  in  1  synchronous active-low reset.
REQ-004 Ports: in_valid  in  1  input sample valid.
REQ-005 Ports: in_ready  out  1  unit accepts the input this cycle.
REQ-006 Ports: in_x  in  DATA_W  signed input sample.
REQ-007 Ports: in_mode  in  1  function select: 0 = tanh, 1 = sigmoid.
REQ-008 Ports: in_tag  in  TAG_W  opaque tag, returned unchanged with the result.
REQ-009 Ports: out_valid  out  1  result valid.
REQ-010 Ports: out_ready  in  1  downstream accepts the result.
REQ-011 Ports: out_y  out  DATA_W  signed result, same Q format as in_x.
REQ-012 Ports: out_tag  out  TAG_W  tag of the result.

Function
REQ-013 Transfers SHALL occur on in_valid&in_ready (input) and out_valid&out_ready (output).
REQ-014 Pipeline: 3 stages (S1 fold/select, S2 shift-add, S3 sign/post); each stage holds a valid bit; global advance enable = ~out_valid | out_ready; in_ready = that enable.
REQ-015 Latency SHALL be exactly 3 cycles from input transfer to out_valid with no backpressure; throughput 1 sample/cycle.
REQ-016 During a stall all stage registers, valid bits and out_y/out_tag SHALL hold; no sample SHALL be dropped, duplicated or reordered.
REQ-017 Sigmoid pre-scale (S1): x' = in_x >>> 1 (arithmetic shift) when in_mode=1; x' = in_x when in_mode=0.
REQ-018 Fold (S1): s = sign of x'; a = |x'|; |most-negative value| SHALL saturate to 2^(DATA_W-1)-1.
REQ-019 Segment table on a (real units): [0,0.5) -> a; [0.5,1.0) -> a>>1 + 0.25; [1.0,1.5) -> a>>2 + 0.5; [1.5,2.0) -> a>>3 + 0.6875; [2.0,3.0) -> a>>4 + 0.8125; >=3.0 -> 1.0.
REQ-020 Breakpoints and biases SHALL be the exact constants above scaled by 2^FRAC_W; boundaries are closed below, open above; shifts truncate the magnitude.
REQ-021 Sign restore (S3): t = s ? -m : m, where m is the segment result; |t| <= 1.0.
REQ-022 Sigmoid post (S3): y = (t >>> 1) + 2^(FRAC_W-1); tanh: y = t.
REQ-023 in_mode and in_tag SHALL travel with their sample through all stages.
REQ-024 The function SHALL be odd-symmetric in tanh mode except for truncation differences at the most-negative input.

Reset
REQ-025 While rst=0 at a clock edge: all valid bits, out_valid, out_y and out_tag SHALL clear to 0; in_ready reads 1 the cycle after rst returns to 1.
REQ-026 Reset asserted mid-stream SHALL discard all in-flight samples; no result SHALL appear for them after reset.

Verification (DATA_W=16, FRAC_W=8, out_ready=1 unless stated)
REQ-027 tanh: in_x 0x0040 -> out_y 0x0040; 0x00C0 -> 0x00A0; 0xFF40 -> 0xFF60; 3 cycles after each input.
REQ-028 Saturation and boundaries: 0x0400 -> 0x0100; 0x8000 -> 0xFF00; 0x0080 -> 0x0080; 0x0300 -> 0x0100.
REQ-029 sigmoid: 0x0000 -> 0x0080; 0x0200 -> 0x00E0; 0xFE00 -> 0x0020; 0x7FFF -> 0x0100.
REQ-030 Backpressure: stream 8 samples with tags 0..7, hold out_ready=0 for cycles 4-8 -> in_ready low while out_valid&~out_ready; all 8 results emerge in tag order with correct values and no duplicates.
REQ-031 Mixed mode: alternate in_mode every cycle with in_x 0x0200 -> outputs alternate 0x00F0 (tanh) and 0x00E0 (sigmoid), tags matching.
REQ-032 Reset mid-operation: 3 samples in flight, rst=0 for one cycle -> out_valid=0 next cycle; none of those samples are emitted; a new sample afterwards returns after 3 cycles.
